// File: rtl/spi_frame_master.sv
// spi_frame_master: streams one pixel frame as a single SPI mode-0 transfer, with ss held low for the whole frame.
// Define SPI_FRAME_CRC_EN to append a CRC-8 byte (poly 0x07, init 0x00) after the payload.
module spi_frame_master #(
  parameter int ROWS            = 8,
  parameter int COLUMNS         = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int CLKDIV          = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  output logic                                             busy,
  output logic                                             done,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]       pix_row,
  output logic [((COLUMNS > 1) ? $clog2(COLUMNS) : 1)-1:0] pix_col,
  input  logic [23:0]                                      pix_data,
  input  logic                                             pix_valid,
  output logic                                             pix_ready,
  output logic                                             spi_sclk,
  output logic                                             spi_ss,
  output logic                                             spi_mosi,
  input  logic                                             spi_miso
);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int TOT = BYTES_PER_PIXEL * 8;
  localparam int CW  = $clog2(2 * CLKDIV);
  localparam int BW  = $clog2(TOT);

  typedef enum logic [2:0] {IDLE, LEAD, FETCH, SHIFT, TRAIL, RECOVER} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [TOT-1:0] sh_q, sh_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic cnt_half_s, cnt_full_s, last_bit_s, last_pix_s, accept_s, crc_phase_s, unused_s;

  assign cnt_half_s = (cnt_q == CW'(CLKDIV - 1));
  assign cnt_full_s = (cnt_q == CW'(2 * CLKDIV - 1));
  assign last_bit_s = crc_phase_s ? (bit_q == BW'(7)) : (bit_q == BW'(TOT - 1));
  assign last_pix_s = (row_q == RW'(ROWS - 1)) && (col_q == CLW'(COLUMNS - 1));
  assign accept_s   = (state_q == IDLE) && start;
  assign unused_s   = ^{spi_miso, pix_data};

`ifdef SPI_FRAME_CRC_EN
  logic [7:0] crc_q, crc_d, crc_next_s;
  logic       crc_phase_q, crc_phase_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? 8'h07 : 8'h00);
  endfunction

  assign crc_next_s  = crc8_step(crc_q, mosi_q);
  assign crc_phase_s = crc_phase_q;

  // CRC register and trailer-phase flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q       <= 8'h00;
      crc_phase_q <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      crc_phase_q <= crc_phase_d;
    end
  end

  // Fold in each payload bit as its cell ends; enter the trailer after the last payload bit
  always_comb begin
    crc_d       = crc_q;
    crc_phase_d = crc_phase_q;
    if (accept_s) begin
      crc_d       = 8'h00;
      crc_phase_d = 1'b0;
    end else if ((state_q == SHIFT) && cnt_full_s && !crc_phase_q) begin
      crc_d       = crc_next_s;
      crc_phase_d = last_bit_s && last_pix_s;
    end else begin
      crc_d = crc_q;
    end
  end
`else
  assign crc_phase_s = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LEAD : IDLE;
      LEAD:    state_d = cnt_half_s ? FETCH : LEAD;
      FETCH:   state_d = (pix_valid && ready_q) ? SHIFT : FETCH;
      SHIFT: begin
        if (cnt_full_s && last_bit_s) begin
          if (crc_phase_s) state_d = TRAIL;
          else if (!last_pix_s) state_d = FETCH;
`ifdef SPI_FRAME_CRC_EN
          else state_d = SHIFT;
`else
          else state_d = TRAIL;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      TRAIL:   state_d = cnt_half_s ? RECOVER : TRAIL;
      RECOVER: state_d = cnt_half_s ? IDLE : RECOVER;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    row_d   = row_q;
    col_d   = col_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          ss_d   = 1'b0;
          cnt_d  = '0;
          row_d  = '0;
          col_d  = '0;
        end else begin
          busy_d = 1'b0;
        end
      end
      LEAD: begin
        if (cnt_half_s) begin
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FETCH: begin
        if (pix_valid && ready_q) begin
          sh_d    = pix_data[TOT-1:0];
          mosi_d  = pix_data[TOT-1];
          ready_d = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          sclk_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_half_s) begin
          sclk_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end else if (cnt_full_s) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (!last_bit_s) begin
            bit_d  = bit_q + BW'(1);
            sh_d   = sh_q << 1;
            mosi_d = sh_q[TOT-2];
          end else if (!crc_phase_s && !last_pix_s) begin
            ready_d = 1'b1;
            if (col_q == CLW'(COLUMNS - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CLW'(1);
            end
          end else begin
`ifdef SPI_FRAME_CRC_EN
            // Trailer byte rides in the top of the shifter so the normal shift path sends it
            if (!crc_phase_s) begin
              bit_d                = '0;
              sh_d                 = '0;
              sh_d[TOT-1 -: 8]     = crc_next_s;
              mosi_d               = crc_next_s[7];
            end else begin
              mosi_d = mosi_q;
            end
`else
            mosi_d = mosi_q;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRAIL: begin
        if (cnt_half_s) begin
          cnt_d  = '0;
          ss_d   = 1'b1;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECOVER: begin
        if (cnt_half_s) begin
          cnt_d  = '0;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        busy_d = 1'b0;
        ss_d   = 1'b1;
        sclk_d = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_ready = ready_q;
  assign spi_sclk  = sclk_q;
  assign spi_ss    = ss_q;
  assign spi_mosi  = mosi_q;
endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: decodes the SPI stream and compares it with a frame model built from the pixel image.
`timescale 1ns/1ps
module tb_spi_frame_master;
  localparam int R0 = 8, C0 = 32, B0 = 2, D0 = 2;
  localparam int R1 = 2, C1 = 4,  B1 = 1, D1 = 1;
`ifdef SPI_FRAME_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0 = 1'b0, valid0 = 1'b0, start1 = 1'b0, valid1 = 1'b0, miso = 1'b0;
  logic busy0, done0, ready0, sclk0, ss0, mosi0;
  logic busy1, done1, ready1, sclk1, ss1, mosi1;
  logic [2:0]  row0;
  logic [4:0]  col0;
  logic [0:0]  row1;
  logic [1:0]  col1;
  logic [23:0] data0, data1;
  logic [23:0] img0 [R0][C0];
  logic [23:0] pix1 = 24'h3CC3A5;

  assign data0 = img0[row0][col0];
  assign data1 = pix1;

  spi_frame_master #(.ROWS(R0), .COLUMNS(C0), .BYTES_PER_PIXEL(B0), .CLKDIV(D0)) dut (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .pix_row(row0), .pix_col(col0), .pix_data(data0), .pix_valid(valid0), .pix_ready(ready0),
    .spi_sclk(sclk0), .spi_ss(ss0), .spi_mosi(mosi0), .spi_miso(miso));

  spi_frame_master #(.ROWS(R1), .COLUMNS(C1), .BYTES_PER_PIXEL(B1), .CLKDIV(D1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .pix_row(row1), .pix_col(col1), .pix_data(data1), .pix_valid(valid1), .pix_ready(ready1),
    .spi_sclk(sclk1), .spi_ss(ss1), .spi_mosi(mosi1), .spi_miso(miso));

  int vectors = 0, errors = 0;
  int rises [2], bad_edges [2], dones [2], ss_rises [2], nb [2];
  int cyc = 0, t_ss_rise = 0, t_busy_fall = 0;
  int timeout = 0, stall_bad = 0, stall_delta = 0;
  logic [7:0] sh [2];
  logic [1:0] psclk = 2'b00, pss = 2'b11, pbusy = 2'b00;
  logic [7:0] got0 [$], got1 [$], exp0 [$], exp1 [$];

  // Receiver model: sample mosi on every sclk rise and assemble MSB-first bytes
  always @(negedge clk) begin
    logic [1:0] s, ss, bz, mo, dn;
    s  = {sclk1, sclk0};
    ss = {ss1, ss0};
    bz = {busy1, busy0};
    mo = {mosi1, mosi0};
    dn = {done1, done0};
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (s[k] && !psclk[k]) begin
        rises[k]++;
        if (ss[k]) bad_edges[k]++;
        sh[k] = {sh[k][6:0], mo[k]};
        nb[k]++;
        if (nb[k] == 8) begin
          nb[k] = 0;
          if (k == 0) got0.push_back(sh[k]);
          else got1.push_back(sh[k]);
        end
      end
      if (ss[k]) nb[k] = 0;
      if (dn[k]) dones[k]++;
      if (ss[k] && !pss[k]) begin
        ss_rises[k]++;
        if (k == 0) t_ss_rise = cyc;
      end
      if (k == 0 && !bz[k] && pbusy[k]) t_busy_fall = cyc;
    end
    psclk = s;
    pss   = ss;
    pbusy = bz;
  end

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      rises[k] = 0; bad_edges[k] = 0; dones[k] = 0; ss_rises[k] = 0; nb[k] = 0;
    end
    got0.delete();
    got1.delete();
  endtask

  task automatic build_exp0();
    logic [7:0] crc, b;
    crc = 8'h00;
    exp0.delete();
    for (int r = 0; r < R0; r++)
      for (int c = 0; c < C0; c++)
        for (int k = B0 - 1; k >= 0; k--) begin
          b = img0[r][c][8*k +: 8];
          exp0.push_back(b);
          crc = crc8_byte(crc, b);
        end
    if (CRC_ON) exp0.push_back(crc);
  endtask

  task automatic set_pattern();
    for (int r = 0; r < R0; r++)
      for (int c = 0; c < C0; c++)
        img0[r][c] = {8'($urandom_range(0, 255)), 8'(r), 8'(c)};
  endtask

  // Drives one frame on dut: optional stall at (0,5), random valid, ignored start pulses
  task automatic run_frame0(input bit stall, input bit rv, input bit extra);
    int n, r0;
    bit stalled, p100, prec;
    clear_mon();
    timeout = 0; stall_bad = 0; stall_delta = 0;
    stalled = 0; p100 = 0; prec = 0; n = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; valid0 = 1'b1;
    while (busy0 && n < 60000) begin
      if (rv) valid0 = ($urandom_range(0, 3) != 0);
      if (stall && !stalled && row0 == 3'd0 && col0 == 5'd5) begin
        stalled = 1; valid0 = 1'b0; r0 = rises[0];
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (sclk0 !== 1'b0 || ss0 !== 1'b0 || ready0 !== 1'b1) stall_bad++;
        end
        stall_delta = rises[0] - r0;
        valid0 = 1'b1; n += 20;
      end
      if (extra && !p100 && got0.size() == 100) begin start0 = 1'b1; p100 = 1; end
      else if (extra && !prec && ss0 && busy0) begin start0 = 1'b1; prec = 1; end
      else start0 = 1'b0;
      @(negedge clk); n++;
    end
    if (n >= 60000) timeout = 1;
    start0 = 1'b0; valid0 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_stream0(input string nm);
    int first;
    vectors++;
    if (timeout != 0) begin errors++; $display("FAIL %s_timeout: busy still high after cycle budget", nm); end
    vectors++;
    if (got0.size() !== exp0.size()) begin
      errors++; $display("FAIL %s_bytes: got %0d bytes, expected %0d", nm, got0.size(), exp0.size());
    end
    first = -1;
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      if (first < 0 && got0[i] !== exp0[i]) first = i;
    vectors++;
    if (first >= 0) begin
      errors++; $display("FAIL %s_data: byte %0d got %02h expected %02h", nm, first, got0[first], exp0[first]);
    end
    vectors++;
    if (rises[0] !== 8 * exp0.size()) begin
      errors++; $display("FAIL %s_edges: got %0d sclk rises, expected %0d", nm, rises[0], 8 * exp0.size());
    end
    vectors++;
    if (dones[0] !== 1 || ss_rises[0] !== 1 || bad_edges[0] !== 0) begin
      errors++; $display("FAIL %s_framing: done=%0d ss_rises=%0d edges_ss_high=%0d, expected 1 1 0",
                         nm, dones[0], ss_rises[0], bad_edges[0]);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({busy0, done0, ready0, ss0, sclk0, mosi0, row0, col0} !== {6'b000100, 3'd0, 5'd0}) begin
      errors++; $display("FAIL reset0: got %b expected %b", {busy0, done0, ready0, ss0, sclk0, mosi0, row0, col0}, {6'b000100, 8'd0});
    end
    vectors++;
    if ({busy1, done1, ready1, ss1, sclk1, mosi1, row1, col1} !== {6'b000100, 1'd0, 2'd0}) begin
      errors++; $display("FAIL reset1: got %b expected %b", {busy1, done1, ready1, ss1, sclk1, mosi1, row1, col1}, {6'b000100, 3'd0});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    set_pattern();
    build_exp0();
    run_frame0(1'b0, 1'b0, 1'b0);
    check_stream0("basic");
    vectors++;
    if (t_busy_fall - t_ss_rise !== D0) begin
      errors++; $display("FAIL basic_recover: busy fell %0d cycles after ss rose, expected %0d", t_busy_fall - t_ss_rise, D0);
    end
  endtask

  task automatic test_stall_and_ignored_start();
    run_frame0(1'b1, 1'b0, 1'b1);
    check_stream0("stall");
    vectors++;
    if (stall_bad !== 0 || stall_delta !== 0) begin
      errors++; $display("FAIL stall_hold: bad cycles %0d, sclk rises %0d, expected 0 0", stall_bad, stall_delta);
    end
    vectors++;
    if (busy0 !== 1'b0 || ss0 !== 1'b1) begin
      errors++; $display("FAIL ignored_start: busy=%b ss=%b after frame, expected 0 1", busy0, ss0);
    end
  endtask

  task automatic test_random_frame();
    for (int r = 0; r < R0; r++)
      for (int c = 0; c < C0; c++) img0[r][c] = 24'($urandom);
    build_exp0();
    run_frame0(1'b0, 1'b1, 1'b0);
    check_stream0("random");
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_mon();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; valid0 = 1'b1;
    n = 0;
    while (got0.size() < 100 && n < 5000) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 5000) begin errors++; $display("FAIL midreset_timeout: only %0d bytes seen", got0.size()); end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({ss0, sclk0, busy0} !== 3'b100) begin
      errors++; $display("FAIL midreset_abort: ss,sclk,busy=%b expected 100", {ss0, sclk0, busy0});
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (dones[0] !== 0) begin errors++; $display("FAIL midreset_done: got %0d done pulses, expected 0", dones[0]); end
    rst = 1'b0; valid0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    vectors++;
    if ({busy0, ss0, row0, col0} !== {2'b10, 3'd0, 5'd0}) begin
      errors++; $display("FAIL midreset_restart: busy,ss,row,col=%b expected %b", {busy0, ss0, row0, col0}, {2'b10, 8'd0});
    end
    #1 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bpp1();
    int n, first;
    logic [7:0] crc, b;
    clear_mon();
    exp1.delete(); crc = 8'h00;
    b = pix1[7:0];
    for (int i = 0; i < R1 * C1 * B1; i++) begin exp1.push_back(b); crc = crc8_byte(crc, b); end
    if (CRC_ON) exp1.push_back(crc);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; valid1 = 1'b1;
    n = 0;
    while (busy1 && n < 2000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    valid1 = 1'b0;
    vectors++;
    if (n >= 2000 || got1.size() !== exp1.size()) begin
      errors++; $display("FAIL bpp1_bytes: got %0d bytes, expected %0d", got1.size(), exp1.size());
    end
    first = -1;
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      if (first < 0 && got1[i] !== exp1[i]) first = i;
    vectors++;
    if (first >= 0) begin errors++; $display("FAIL bpp1_data: byte %0d got %02h expected %02h", first, got1[first], exp1[first]); end
    vectors++;
    if (rises[1] !== 8 * exp1.size() || dones[1] !== 1) begin
      errors++; $display("FAIL bpp1_edges: rises=%0d done=%0d expected %0d 1", rises[1], dones[1], 8 * exp1.size());
    end
  endtask

`ifdef SPI_FRAME_CRC_EN
  task automatic test_crc();
    for (int r = 0; r < R0; r++)
      for (int c = 0; c < C0; c++) img0[r][c] = 24'h000000;
    img0[R0-1][C0-1] = 24'h000102;
    build_exp0();
    run_frame0(1'b0, 1'b0, 1'b0);
    check_stream0("crc");
    vectors++;
    if (got0.size() !== 513 || got0[got0.size()-1] !== 8'h1B) begin
      errors++; $display("FAIL crc_byte: size %0d last %02h, expected 513 1b", got0.size(),
                         (got0.size() > 0) ? got0[got0.size()-1] : 8'h00);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic_frame();
    test_stall_and_ignored_start();
    test_random_frame();
    test_reset_mid_frame();
    test_bpp1();
`ifdef SPI_FRAME_CRC_EN
    test_crc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
